// File: rtl/clock_trig_mon.sv
// rtl/clock_trig_mon.sv - receive-side checker for the periodic clock trigger
//
// Purpose:
//   While in_live is high, measures the spacing of in_trig pulses against the
//   expected interval E = user_gap + 1. Flags EARLY (pulse before E) and MISS
//   (no pulse by E) errors, keeps saturating trigger/error counts and asserts
//   out_lock after LOCK_N consecutive good intervals.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-high reset
//   in_live      - run window; monitoring only while high
//   in_trig      - incoming one-cycle trigger pulse
//   user_gap     - programmed gap, E = user_gap + 1 cycles
//   out_period   - last measured interval (cycles)
//   out_n_trig   - triggers in current run, saturating
//   out_n_err    - errors in current run, saturating
//   out_err      - one-cycle error pulse
//   out_err_code - 01 EARLY, 10 MISS while out_err is high, else 00
//   out_lock     - stream locked

module clock_trig_mon #(
  parameter int unsigned LOCK_N = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_live,
  input  logic        in_trig,
  input  logic [31:0] user_gap,
  output logic [31:0] out_period,
  output logic [31:0] out_n_trig,
  output logic [15:0] out_n_err,
  output logic        out_err,
  output logic [1:0]  out_err_code,
  output logic        out_lock
);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_EARLY = 2'b01;
  localparam logic [1:0] CODE_MISS  = 2'b10;
  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    TRACK      = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        live_q;
  logic [32:0] cnt, cnt_nxt;
  logic [7:0]  good_cnt, good_nxt;

  logic [31:0] period_nxt;
  logic [31:0] n_trig_nxt;
  logic [15:0] n_err_nxt;
  logic        err_nxt;
  logic [1:0]  code_nxt;
  logic        lock_nxt;

  // E is 33 bits wide so user_gap = 0xFFFFFFFF gives 2^32 rather than 0.
  logic [32:0] exp_gap;
  logic [31:0] n_trig_inc;
  logic [15:0] n_err_inc;
  logic [7:0]  good_inc;
  logic [31:0] cnt_meas;

  assign exp_gap    = {1'b0, user_gap} + 33'd1;
  assign n_trig_inc = (out_n_trig == 32'hFFFF_FFFF) ? out_n_trig : out_n_trig + 32'd1;
  assign n_err_inc  = (out_n_err == 16'hFFFF) ? out_n_err : out_n_err + 16'd1;
  assign good_inc   = (good_cnt >= LOCK_TARGET) ? good_cnt : good_cnt + 8'd1;
  // A good interval of exactly 2^32 cycles cannot be shown in 32 bits; clamp it.
  assign cnt_meas   = cnt[32] ? 32'hFFFF_FFFF : cnt[31:0];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    good_nxt   = good_cnt;
    period_nxt = out_period;
    n_trig_nxt = out_n_trig;
    n_err_nxt  = out_n_err;
    err_nxt    = 1'b0;
    code_nxt   = CODE_NONE;
    lock_nxt   = out_lock;

    case (state)
      IDLE: begin
        lock_nxt = 1'b0;
        cnt_nxt  = 33'd0;
        if (in_live && !live_q) begin
          period_nxt = 32'd0;
          n_trig_nxt = 32'd0;
          n_err_nxt  = 16'd0;
          good_nxt   = 8'd0;
          state_nxt  = WAIT_FIRST;
        end
      end

      WAIT_FIRST: begin
        if (!in_live) begin
          lock_nxt  = 1'b0;
          cnt_nxt   = 33'd0;
          state_nxt = IDLE;
        end else if (in_trig) begin
          n_trig_nxt = n_trig_inc;
          cnt_nxt    = 33'd1;
          state_nxt  = TRACK;
        end
      end

      TRACK: begin
        if (!in_live) begin
          // Leaving the run drops any error this edge would have raised.
          lock_nxt  = 1'b0;
          cnt_nxt   = 33'd0;
          state_nxt = IDLE;
        end else if (in_trig && (cnt == exp_gap)) begin
          n_trig_nxt = n_trig_inc;
          period_nxt = cnt_meas;
          cnt_nxt    = 33'd1;
          good_nxt   = good_inc;
          lock_nxt   = (good_inc >= LOCK_TARGET);
        end else if (in_trig && (cnt < exp_gap)) begin
          n_trig_nxt = n_trig_inc;
          period_nxt = cnt_meas;
          cnt_nxt    = 33'd1;
          good_nxt   = 8'd0;
          lock_nxt   = 1'b0;
          n_err_nxt  = n_err_inc;
          err_nxt    = 1'b1;
          code_nxt   = CODE_EARLY;
        end else if (cnt >= exp_gap) begin
          // Overdue (or gap shrunk under the count): insert a virtual trigger
          // to re-phase. A real pulse that coincides is still counted.
          if (in_trig) begin
            n_trig_nxt = n_trig_inc;
          end
          cnt_nxt   = 33'd1;
          good_nxt  = 8'd0;
          lock_nxt  = 1'b0;
          n_err_nxt = n_err_inc;
          err_nxt   = 1'b1;
          code_nxt  = CODE_MISS;
        end else begin
          cnt_nxt = cnt + 33'd1;
        end
      end

      default: begin
        lock_nxt  = 1'b0;
        cnt_nxt   = 33'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q       <= 1'b0;
      cnt          <= 33'd0;
      good_cnt     <= 8'd0;
      out_period   <= 32'd0;
      out_n_trig   <= 32'd0;
      out_n_err    <= 16'd0;
      out_err      <= 1'b0;
      out_err_code <= CODE_NONE;
      out_lock     <= 1'b0;
    end else begin
      live_q       <= in_live;
      cnt          <= cnt_nxt;
      good_cnt     <= good_nxt;
      out_period   <= period_nxt;
      out_n_trig   <= n_trig_nxt;
      out_n_err    <= n_err_nxt;
      out_err      <= err_nxt;
      out_err_code <= code_nxt;
      out_lock     <= lock_nxt;
    end
  end

endmodule

// File: tb/tb_clock_trig_mon.sv
// tb/tb_clock_trig_mon.sv - self-checking bench for clock_trig_mon

module tb_clock_trig_mon;

  localparam int LOCK_N = 4;

  logic        clk;
  logic        reset;
  logic        in_live;
  logic        in_trig;
  logic [31:0] user_gap;
  logic [31:0] out_period;
  logic [31:0] out_n_trig;
  logic [15:0] out_n_err;
  logic        out_err;
  logic [1:0]  out_err_code;
  logic        out_lock;

  int checks = 0;
  int errors = 0;

  clock_trig_mon #(.LOCK_N(LOCK_N)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_live      (in_live),
    .in_trig      (in_trig),
    .user_gap     (user_gap),
    .out_period   (out_period),
    .out_n_trig   (out_n_trig),
    .out_n_err    (out_n_err),
    .out_err      (out_err),
    .out_err_code (out_err_code),
    .out_lock     (out_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [83:0] dut_vec;
  assign dut_vec = {out_period, out_n_trig, out_n_err, out_err, out_err_code, out_lock};

  // Reference model: timestamps of the last real/virtual trigger.
  longint      now;
  longint      m_last;
  bit          m_run;
  bit          m_seen;
  int          m_streak;
  logic [31:0] m_period;
  logic [31:0] m_ntrig;
  logic [15:0] m_nerr;
  logic        m_err;
  logic [1:0]  m_code;
  logic        m_lock;

  function automatic logic [83:0] model_vec();
    return {m_period, m_ntrig, m_nerr, m_err, m_code, m_lock};
  endfunction

  task automatic model_reset();
    now = 0; m_last = 0; m_run = 0; m_seen = 0; m_streak = 0;
    m_period = 0; m_ntrig = 0; m_nerr = 0; m_err = 0; m_code = 0; m_lock = 0;
  endtask

  task automatic model_error(input logic [1:0] code);
    if (m_nerr != 16'hFFFF) m_nerr = m_nerr + 16'd1;
    m_err = 1'b1;
    m_code = code;
    m_streak = 0;
  endtask

  task automatic model_step(input bit live, input bit trig);
    longint e;
    longint d;
    now = now + 1;
    e = {32'b0, user_gap};
    e = e + 1;
    m_err = 1'b0;
    m_code = 2'b00;
    if (!live) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1; m_seen = 0; m_streak = 0;
      m_period = 0; m_ntrig = 0; m_nerr = 0;
    end else if (!m_seen) begin
      if (trig) begin
        m_seen = 1;
        m_last = now;
        if (m_ntrig != 32'hFFFF_FFFF) m_ntrig = m_ntrig + 32'd1;
      end
    end else begin
      d = now - m_last;
      if (trig && m_ntrig != 32'hFFFF_FFFF) m_ntrig = m_ntrig + 32'd1;
      if (trig && d == e) begin
        m_period = d[31:0];
        m_last = now;
        if (m_streak < LOCK_N) m_streak = m_streak + 1;
      end else if (trig && d < e) begin
        m_period = d[31:0];
        m_last = now;
        model_error(2'b01);
      end else if (d >= e) begin
        m_last = now;
        model_error(2'b10);
      end
    end
    m_lock = (live && m_run && m_streak >= LOCK_N);
  endtask

  task automatic step(input bit live, input bit trig);
    in_live = live;
    in_trig = trig;
    @(posedge clk);
    model_step(live, trig);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_live = 1'b0;
    in_trig = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_live = 1'b0;
    in_trig = 1'b0;
    user_gap = 32'd9;
    repeat (2) @(negedge clk);
    checks++; if (out_period !== 32'd0) begin errors++; $display("FAIL reset_period got %h want 0", out_period); end
    checks++; if (out_n_trig !== 32'd0) begin errors++; $display("FAIL reset_n_trig got %h want 0", out_n_trig); end
    checks++; if (out_n_err !== 16'd0) begin errors++; $display("FAIL reset_n_err got %h want 0", out_n_err); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", out_err); end
    checks++; if (out_err_code !== 2'b00) begin errors++; $display("FAIL reset_code got %b want 00", out_err_code); end
    checks++; if (out_lock !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", out_lock); end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      checks++; if (dut_vec !== 84'd0) begin errors++; $display("FAIL idle_ignore got %h want 0", dut_vec); end
    end
  endtask

  task automatic test_nominal();
    do_reset();
    user_gap = 32'd9;
    step(1'b1, 1'b0);
    for (int p = 1; p <= 20; p++) begin
      step(1'b1, 1'b1);
      checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL nominal pulse %0d got %h want %h", p, dut_vec, model_vec()); end
      if (p == 4) begin
        checks++; if (out_lock !== 1'b0) begin errors++; $display("FAIL nominal_lock_early got %b want 0", out_lock); end
      end
      if (p == 5) begin
        checks++; if (out_lock !== 1'b1) begin errors++; $display("FAIL nominal_lock_rise got %b want 1", out_lock); end
      end
      for (int i = 0; i < 9; i++) begin
        step(1'b1, 1'b0);
        checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL nominal gap got %h want %h", dut_vec, model_vec()); end
      end
    end
    checks++; if (out_period !== 32'd10) begin errors++; $display("FAIL nominal_period got %0d want 10", out_period); end
    checks++; if (out_n_trig !== 32'd20) begin errors++; $display("FAIL nominal_n_trig got %0d want 20", out_n_trig); end
    checks++; if (out_n_err !== 16'd0) begin errors++; $display("FAIL nominal_n_err got %0d want 0", out_n_err); end
    checks++; if (out_lock !== 1'b1) begin errors++; $display("FAIL nominal_lock got %b want 1", out_lock); end
  endtask

  task automatic test_miss();
    do_reset();
    user_gap = 32'd9;
    step(1'b1, 1'b0);
    for (int p = 1; p <= 14; p++) begin
      step(1'b1, (p != 6));
      checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL miss slot %0d got %h want %h", p, dut_vec, model_vec()); end
      if (p == 6) begin
        checks++; if ({out_err, out_err_code} !== 3'b110) begin errors++; $display("FAIL miss_pulse got %b want 110", {out_err, out_err_code}); end
        checks++; if (out_lock !== 1'b0) begin errors++; $display("FAIL miss_lock_fall got %b want 0", out_lock); end
      end
      if (p == 9) begin
        checks++; if (out_lock !== 1'b0) begin errors++; $display("FAIL miss_relock_early got %b want 0", out_lock); end
      end
      if (p == 10) begin
        checks++; if (out_lock !== 1'b1) begin errors++; $display("FAIL miss_relock got %b want 1", out_lock); end
      end
      for (int i = 0; i < 9; i++) begin
        step(1'b1, 1'b0);
        checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL miss gap got %h want %h", dut_vec, model_vec()); end
      end
    end
    checks++; if (out_n_err !== 16'd1) begin errors++; $display("FAIL miss_n_err got %0d want 1", out_n_err); end
    checks++; if (out_n_trig !== 32'd13) begin errors++; $display("FAIL miss_n_trig got %0d want 13", out_n_trig); end
  endtask

  task automatic test_early();
    int spacing [4] = '{0, 10, 7, 3};
    do_reset();
    user_gap = 32'd9;
    step(1'b1, 1'b0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 1; i < spacing[p]; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL early pulse %0d got %h want %h", p, dut_vec, model_vec()); end
    end
    // State after the 3-cycle pulse; the 7-cycle one was checked by the model.
    checks++; if ({out_err, out_err_code} !== 3'b101) begin errors++; $display("FAIL early_code got %b want 101", {out_err, out_err_code}); end
    checks++; if (out_period !== 32'd3) begin errors++; $display("FAIL early_period got %0d want 3", out_period); end
    checks++; if (out_n_err !== 16'd2) begin errors++; $display("FAIL early_n_err got %0d want 2", out_n_err); end
    step(1'b1, 1'b0);
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL early_pulse_width got %b want 0", out_err); end
  endtask

  task automatic test_gap0();
    do_reset();
    user_gap = 32'd0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1);
      checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL gap0 cycle %0d got %h want %h", i, dut_vec, model_vec()); end
    end
    checks++; if (out_n_err !== 16'd0) begin errors++; $display("FAIL gap0_n_err got %0d want 0", out_n_err); end
    checks++; if (out_lock !== 1'b1) begin errors++; $display("FAIL gap0_lock got %b want 1", out_lock); end
    checks++; if (out_period !== 32'd1) begin errors++; $display("FAIL gap0_period got %0d want 1", out_period); end
  endtask

  task automatic test_gap_max();
    do_reset();
    user_gap = 32'hFFFF_FFFF;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    force dut.cnt = 33'h0_FFFF_FFFE;
    #1;
    release dut.cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      if (i < 2) begin
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL gapmax_early_miss step %0d got %b want 0", i, out_err); end
      end else begin
        checks++; if ({out_err, out_err_code} !== 3'b110) begin errors++; $display("FAIL gapmax_miss got %b want 110", {out_err, out_err_code}); end
        checks++; if (out_n_err !== 16'd1) begin errors++; $display("FAIL gapmax_n_err got %0d want 1", out_n_err); end
      end
    end
  endtask

  task automatic test_live();
    do_reset();
    user_gap = 32'd9;
    step(1'b1, 1'b0);
    for (int p = 0; p < 8; p++) begin
      step(1'b1, 1'b1);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    end
    step(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL live_hold got %h want %h", dut_vec, model_vec()); end
    end
    checks++; if (out_n_trig !== 32'd8) begin errors++; $display("FAIL live_held_n_trig got %0d want 8", out_n_trig); end
    checks++; if (out_lock !== 1'b0) begin errors++; $display("FAIL live_lock_drop got %b want 0", out_lock); end
    step(1'b1, 1'b1);
    checks++; if (dut_vec !== 84'd0) begin errors++; $display("FAIL live_clear got %h want 0", dut_vec); end
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++; if ({out_n_trig, out_n_err, out_err} !== {32'd1, 16'd0, 1'b0}) begin errors++; $display("FAIL live_first got %h want 000000010000 0", {out_n_trig, out_n_err, out_err}); end
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL live_second got %h want %h", dut_vec, model_vec()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    user_gap = 32'd2;
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (dut_vec !== 84'd0) begin errors++; $display("FAIL async_reset got %h want 0", dut_vec); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    user_gap = 32'd9;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    force dut.out_n_trig = 32'hFFFF_FFFE;
    force dut.out_n_err = 16'hFFFE;
    #1;
    release dut.out_n_trig;
    release dut.out_n_err;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      checks++; if (out_n_trig !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_n_trig ev %0d got %h want ffffffff", i, out_n_trig); end
      checks++; if (out_n_err !== 16'hFFFF) begin errors++; $display("FAIL sat_n_err ev %0d got %h want ffff", i, out_n_err); end
      checks++; if ({out_err, out_err_code} !== 3'b101) begin errors++; $display("FAIL sat_err ev %0d got %b want 101", i, {out_err, out_err_code}); end
    end
  endtask

  task automatic test_random();
    int e;
    int cd;
    int k;
    bit t;
    do_reset();
    for (int run = 0; run < 6; run++) begin
      user_gap = $urandom_range(2, 8);
      e = int'(user_gap) + 1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      cd = $urandom_range(0, 4);
      for (int c = 0; c < 150; c++) begin
        t = (cd == 0);
        if (t) begin
          k = e + int'($urandom_range(0, 4)) - 2;
          if (k < 1) k = 1;
          cd = k - 1;
        end else begin
          cd = cd - 1;
        end
        step(1'b1, t);
        checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL random run %0d cyc %0d got %h want %h", run, c, dut_vec, model_vec()); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_miss();
    test_early();
    test_gap0();
    test_gap_max();
    test_live();
    test_async_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
